// File: rtl/pico_seq_pkg.sv
// Shared opcodes, FSM state encoding and instruction field positions for pico_seq.
package pico_seq_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [2:0] OP_JMP  = 3'b000;
    localparam logic [2:0] OP_JC   = 3'b001;
    localparam logic [2:0] OP_CALL = 3'b010;
    localparam logic [2:0] OP_RET  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b100;
    localparam logic [2:0] OP_LDC  = 3'b101;
    localparam logic [2:0] OP_DJNZ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    localparam int BIT_CTRL = 15;
    localparam int OPC_MSB  = 14;
    localparam int OPC_LSB  = 12;
    localparam int LC_MSB   = 7;

endpackage

// File: rtl/pico_seq_stack.sv
// Return-address LIFO for pico_seq; push/pop are ignored when full/empty respectively.
module pico_seq_stack #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_full,
    output logic              o_empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_rd_idx  = IDX_W'(r_sp - SP_W'(1));
    assign o_top     = r_mem[w_rd_idx];
    assign o_full    = (r_sp == SP_W'(DEPTH));
    assign o_empty   = (r_sp == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (w_do_pop) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // Storage carries no reset: entries above the pointer are never read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_sp[IDX_W-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/pico_seq.sv
// Two-cycle microsequencer fetching from a 1-cycle-latency ROM.
// Define PICO_SEQ_LOOP_EN to add the 8-bit loop counter (LDC / DJNZ); otherwise those opcodes are NOPs.
module pico_seq
    import pico_seq_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int INSTR_W     = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               RUN,
    input  logic               COND,
    output logic [ADDR_W-1:0]  RADDR,
    input  logic [INSTR_W-1:0] RDATA,
    output logic [DATA_W-1:0]  O,
    output logic [ADDR_W-1:0]  PC,
    output logic               HALTED,
    output logic               ERR
);
    // state    | meaning
    // ST_FETCH | RADDR=PC presented, ROM latches word; wait for RUN
    // ST_EXEC  | decode RDATA, update PC/O/stack
    // ST_HALT  | terminal until reset, HALTED=1

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_o;
    logic              r_halted;
    logic              r_err;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_stack_top;
    logic [2:0]        w_opc;
    logic              w_is_ctrl;
    logic              w_exec;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_unused;

`ifdef PICO_SEQ_LOOP_EN
    logic [7:0]        r_lc;
    logic [7:0]        w_lc_dec;
    assign w_lc_dec = r_lc - 8'd1;
`endif

    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_target  = RDATA[ADDR_W-1:0];
    assign w_is_ctrl = RDATA[BIT_CTRL];
    assign w_opc     = RDATA[OPC_MSB:OPC_LSB];
    assign w_exec    = (r_state == ST_EXEC);
    assign w_push    = w_exec && w_is_ctrl && (w_opc == OP_CALL) && !w_full;
    assign w_pop     = w_exec && w_is_ctrl && (w_opc == OP_RET) && !w_empty;
    assign w_unused  = ^RDATA;

    assign RADDR  = r_pc;
    assign PC     = r_pc;
    assign O      = r_o;
    assign HALTED = r_halted;
    assign ERR    = r_err;

    pico_seq_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .i_clk   (CLK),
        .i_rst_n (RESETN),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_stack_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state  <= ST_FETCH;
            r_pc     <= '0;
            r_o      <= '0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
`ifdef PICO_SEQ_LOOP_EN
            r_lc     <= '0;
`endif
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (RUN) begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_FETCH;
                    if (!w_is_ctrl) begin
                        r_o  <= RDATA[DATA_W-1:0];
                        r_pc <= w_pc_inc;
                    end else begin
                        case (w_opc)
                            OP_JMP: r_pc <= w_target;
                            OP_JC:  r_pc <= COND ? w_target : w_pc_inc;
                            OP_CALL: begin
                                // Overflowing call neither pushes nor jumps.
                                if (w_full) begin
                                    r_err    <= 1'b1;
                                    r_halted <= 1'b1;
                                    r_state  <= ST_HALT;
                                end else begin
                                    r_pc <= w_target;
                                end
                            end
                            OP_RET: begin
                                if (w_empty) begin
                                    r_err    <= 1'b1;
                                    r_halted <= 1'b1;
                                    r_state  <= ST_HALT;
                                end else begin
                                    r_pc <= w_stack_top;
                                end
                            end
                            OP_HALT: begin
                                r_halted <= 1'b1;
                                r_state  <= ST_HALT;
                            end
`ifdef PICO_SEQ_LOOP_EN
                            OP_LDC: begin
                                r_lc <= RDATA[LC_MSB:0];
                                r_pc <= w_pc_inc;
                            end
                            OP_DJNZ: begin
                                r_lc <= w_lc_dec;
                                r_pc <= (w_lc_dec != 8'd0) ? w_target : w_pc_inc;
                            end
`endif
                            default: r_pc <= w_pc_inc;
                        endcase
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: doc/pico_seq.md
Name: pico_seq

Overview:
- Parametrised microsequencer: fetches instruction words from an external synchronous ROM (block RAM, 1-cycle read latency) and drives a registered output port.
- Generalises the fixed 8-bit PC / jump-only sequencer with:
  - parametrised widths;
  - conditional jump, subroutine call/return with hardware stack, halt, run gating and error flag.
- Sits between the board clock/reset and the ROM primitive; O drives board pins (LEDs/J3 header).

Parameters:
- ADDR_W, 8, program-counter/ROM address width; legal range 4..12.
- DATA_W, 8, output register width; legal range 1..12.
- INSTR_W, 16, instruction word width; fixed at 16 for SB_RAM40_4K 256x16 mode.
- STACK_DEPTH, 4, return-address stack entries; power of two, 2..16.

Ports:
- CLK  in  1  system clock, rising edge.
- RESETN  in  1  asynchronous active-low reset.
- RUN  in  1  execution enable; low stalls in FETCH.
- COND  in  1  condition flag for JC, sampled in EXEC.
- RADDR  out  ADDR_W  ROM read address; combinational, equals PC.
- RDATA  in  INSTR_W  ROM read data; valid the cycle after RADDR is presented.
- O  out  DATA_W  registered output port.
- PC  out  ADDR_W  current program counter.
- HALTED  out  1  high while in HALT state.
- ERR  out  1  sticky stack over/underflow flag.

Behaviour:
- Reset (asynchronous on RESETN low) sets: PC=0, O=0, state=FETCH, stack pointer=0, HALTED=0, ERR=0, loop counter=0.
- States:
  - FETCH: RADDR=PC; ROM latches the word on this edge. If RUN=1 go to EXEC, else stay.
  - EXEC: decode RDATA, update PC/O/stack, then return to FETCH (or go to HALT).
  - HALT: remains until reset; HALTED=1.
- Throughput: 2 cycles per instruction; no pipelining.
- Encoding (A = RDATA[ADDR_W-1:0]):
  - RDATA[15]=0: LDO. O <= RDATA[DATA_W-1:0]; PC <= PC+1.
  - RDATA[15]=1: opcode RDATA[14:12]:
    - 000 JMP: PC <= A.
    - 001 JC: PC <= A if COND=1, else PC+1.
    - 010 CALL: push PC+1, PC <= A.
    - 011 RET: PC <= pop.
    - 100 HALT: PC unchanged, go to HALT.
    - 101/110: loop ops (see Optional Feature), otherwise NOP.
    - 111 NOP: PC <= PC+1.
- PC+1 wraps modulo 2^ADDR_W (max to 0) with no flag. Pushed return addresses also wrap.
- Stack overflow: CALL with STACK_DEPTH entries already held → no push, no jump, ERR<=1, go to HALT.
- Stack underflow: RET on empty stack → ERR<=1, go to HALT.
- O changes only on LDO in EXEC; holds through stalls and HALT.
- RUN low in EXEC does not abort the current instruction; the stall takes effect at the next FETCH.
- Reset during EXEC discards the in-flight instruction; the next fetch is from address 0.

Optional Feature:
- Macro PICO_SEQ_LOOP_EN.
- Defined: adds an 8-bit loop counter LC, reset 0.
  - 101 LDC: LC <= RDATA[7:0]; PC <= PC+1.
  - 110 DJNZ: LC <= LC-1; PC <= A if (LC-1)!=0, else PC+1. DJNZ with LC=0 wraps to 255 and jumps.
- Undefined: no LC register; 101 and 110 execute as NOP (PC+1).

Decomposition:
- Package pico_seq_pkg holds:
  - opcode localparams OP_JMP, OP_JC, OP_CALL, OP_RET, OP_HALT, OP_LDC, OP_DJNZ, OP_NOP;
  - state encoding ST_FETCH, ST_EXEC, ST_HALT;
  - instruction field bit positions.
- One sub-module: pico_seq_stack.
  - Parametrised LIFO (ADDR_W x STACK_DEPTH) with push/pop strobes and full/empty outputs.
  - Same asynchronous active-low reset.

Test Plan:
- Reset, RUN=1; ROM[0]=0x00A5, ROM[1]=0x8000 (JMP 0) → O=0xA5 at cycle 2. PC sequence 0,1,0,1 changes every 2 cycles. RADDR tracks PC.
- ROM[0]=0x9005 (JC 5), ROM[1]=0x003C, ROM[5]=0x00C3:
  - COND=1 → PC=5, O=0xC3.
  - Repeat with COND=0 → PC=1, O=0x3C.
- ROM[0]=0xA010 (CALL 0x10), ROM[0x10]=0x0011, ROM[0x11]=0xB000 (RET), ROM[1]=0xC000 (HALT) → O=0x11; PC returns to 1; HALTED=1; ERR=0; PC stays 1.
- ROM[0]=0xA000 (CALL 0, recursive), STACK_DEPTH=4 → fifth CALL sets ERR=1 and HALTED=1 with PC=0. Pulse RESETN low mid-run → all outputs clear asynchronously.
- Hold RUN=0 for 10 cycles after reset → PC=0, O=0 stay constant. ROM[0xFF]=0x0077 with PC reaching 0xFF → next PC=0x00.
- With PICO_SEQ_LOOP_EN: LDC 3, then body LDO toggling, then DJNZ to body → body executes exactly 3 times. Without the macro, the same image treats 0xD000/0xE000 as NOP.
